// File: rtl/isp_frame_sequencer_if.sv
// Demosaic pipeline link for the ISP frame sequencer.
// Carries the shadowed geometry and pipeline reset toward the demosaic /
// white-balance stages, the pixel-valid and end-of-frame strobes back from
// them, and the RGB writeback strobe and address.
//   master : sequencer side (drives geometry, dm_reset, wr_en, wr_adr)
//   slave  : pipeline / writeback side
interface isp_frame_sequencer_if;

    localparam int unsigned GEOM_W = 16;
    localparam int unsigned ADR_W  = 32;

    logic [GEOM_W-1:0] dm_width;
    logic [GEOM_W-1:0] dm_height;
    logic [GEOM_W-1:0] dm_crop_w;
    logic [GEOM_W-1:0] dm_crop_h;
    logic              dm_reset;
    logic              dm_data_v;
    logic              dm_done;
    logic              wr_en;
    logic [ADR_W-1:0]  wr_adr;

    modport master (
        output dm_width,
        output dm_height,
        output dm_crop_w,
        output dm_crop_h,
        output dm_reset,
        input  dm_data_v,
        input  dm_done,
        output wr_en,
        output wr_adr
    );

    modport slave (
        input  dm_width,
        input  dm_height,
        input  dm_crop_w,
        input  dm_crop_h,
        input  dm_reset,
        output dm_data_v,
        output dm_done,
        input  wr_en,
        input  wr_adr
    );

endinterface

// File: rtl/isp_frame_sequencer.sv
// ISP frame sequencer.
// Accepts a start request with a frame geometry, shadows the geometry to the
// demosaic pipeline, holds the pipeline in reset for two cycles, then counts
// valid pixels while generating RGB writeback addresses. A frame ends on the
// pipeline's end-of-frame strobe or on a stall watchdog expiry.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset
//   start      : frame request, honoured only while idle
//   cfg_*      : requested geometry (width, height, crop width, crop height)
//   dm         : pipeline link (geometry shadows, dm_reset, strobes, writeback)
//   busy       : frame in progress (clear, run or done)
//   frame_done : one-cycle end-of-frame pulse
//   err        : sticky errors {bad geometry, watchdog, pixel count mismatch}
//   pix_count  : saturating count of valid pixels in the current frame
module isp_frame_sequencer #(
    parameter logic [31:0] OUT_BASE  = 32'h0020_0000,
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           cfg_width,
    input  logic [15:0]           cfg_height,
    input  logic [15:0]           cfg_crop_w,
    input  logic [15:0]           cfg_crop_h,
    isp_frame_sequencer_if.master dm,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            err,
    output logic [31:0]           pix_count
);

    localparam int unsigned GEOM_W  = 16;
    localparam int unsigned ADR_W   = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_CLEAR = 2'd1;
    localparam logic [STATE_W-1:0] S_RUN   = 2'd2;
    localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

    localparam int unsigned ERR_COUNT = 0;
    localparam int unsigned ERR_WDOG  = 1;
    localparam int unsigned ERR_GEOM  = 2;

    localparam logic [GEOM_W-1:0] MIN_DIM = GEOM_W'(2);

    // State and registered outputs
    logic [STATE_W-1:0]   state_q,      state_nxt;
    logic                 clear_cnt_q,  clear_cnt_nxt;
    logic [TIMEOUT_W-1:0] wdog_q,       wdog_nxt;
    logic [GEOM_W-1:0]    width_q,      width_nxt;
    logic [GEOM_W-1:0]    height_q,     height_nxt;
    logic [GEOM_W-1:0]    crop_w_q,     crop_w_nxt;
    logic [GEOM_W-1:0]    crop_h_q,     crop_h_nxt;
    logic                 dm_reset_q,   dm_reset_nxt;
    logic                 wr_en_q,      wr_en_nxt;
    logic [ADR_W-1:0]     wr_adr_q,     wr_adr_nxt;
    logic                 busy_q,       busy_nxt;
    logic                 frame_done_q, frame_done_nxt;
    logic [ERR_W-1:0]     err_q,        err_nxt;
    logic [CNT_W-1:0]     pix_q,        pix_nxt;

    // Datapath helpers
    logic                 geom_ok_c;
    logic [CNT_W-1:0]     pix_inc_c;
    logic [CNT_W-1:0]     pix_final_c;
    logic [CNT_W-1:0]     frame_px_c;
    logic [TIMEOUT_W-1:0] wdog_inc_c;
    logic                 wdog_expire_c;

    assign geom_ok_c     = (cfg_width >= MIN_DIM) && (cfg_height >= MIN_DIM);
    assign pix_inc_c     = (pix_q == '1) ? pix_q : pix_q + CNT_W'(1);
    // Count including a valid pixel arriving in the same cycle as dm_done
    assign pix_final_c   = dm.dm_data_v ? pix_inc_c : pix_q;
    assign frame_px_c    = CNT_W'(width_q) * CNT_W'(height_q);
    assign wdog_inc_c    = wdog_q + TIMEOUT_W'(1);
    // Expires on the cycle the watchdog would step onto all-ones
    assign wdog_expire_c = !dm.dm_data_v && (wdog_inc_c == '1);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            clear_cnt_q  <= 1'b0;
            wdog_q       <= '0;
            width_q      <= '0;
            height_q     <= '0;
            crop_w_q     <= '0;
            crop_h_q     <= '0;
            dm_reset_q   <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_adr_q     <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
            pix_q        <= '0;
        end else begin
            state_q      <= state_nxt;
            clear_cnt_q  <= clear_cnt_nxt;
            wdog_q       <= wdog_nxt;
            width_q      <= width_nxt;
            height_q     <= height_nxt;
            crop_w_q     <= crop_w_nxt;
            crop_h_q     <= crop_h_nxt;
            dm_reset_q   <= dm_reset_nxt;
            wr_en_q      <= wr_en_nxt;
            wr_adr_q     <= wr_adr_nxt;
            busy_q       <= busy_nxt;
            frame_done_q <= frame_done_nxt;
            err_q        <= err_nxt;
            pix_q        <= pix_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state_q;
        clear_cnt_nxt = clear_cnt_q;
        wdog_nxt      = wdog_q;
        width_nxt     = width_q;
        height_nxt    = height_q;
        crop_w_nxt    = crop_w_q;
        crop_h_nxt    = crop_h_q;
        wr_en_nxt     = 1'b0;
        wr_adr_nxt    = wr_adr_q;
        err_nxt       = err_q;
        pix_nxt       = pix_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (geom_ok_c) begin
                        width_nxt     = cfg_width;
                        height_nxt    = cfg_height;
                        crop_w_nxt    = cfg_crop_w;
                        crop_h_nxt    = cfg_crop_h;
                        err_nxt       = '0;
                        pix_nxt       = '0;
                        wdog_nxt      = '0;
                        clear_cnt_nxt = 1'b0;
                        state_nxt     = S_CLEAR;
                    end else begin
                        err_nxt[ERR_GEOM] = 1'b1;
                    end
                end
            end

            // Two-cycle pipeline flush
            S_CLEAR: begin
                if (clear_cnt_q) begin
                    state_nxt = S_RUN;
                end else begin
                    clear_cnt_nxt = 1'b1;
                end
            end

            S_RUN: begin
                wr_en_nxt = dm.dm_data_v;
                if (dm.dm_data_v) begin
                    wr_adr_nxt = OUT_BASE + pix_q;
                    pix_nxt    = pix_inc_c;
                    wdog_nxt   = '0;
                end else begin
                    wdog_nxt   = wdog_inc_c;
                end
                // End-of-frame outranks a simultaneous watchdog expiry
                if (dm.dm_done) begin
                    state_nxt = S_DONE;
                    if (pix_final_c != frame_px_c) begin
                        err_nxt[ERR_COUNT] = 1'b1;
                    end
                end else if (wdog_expire_c) begin
                    state_nxt         = S_DONE;
                    err_nxt[ERR_WDOG] = 1'b1;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Status outputs follow the state being entered
        dm_reset_nxt   = (state_nxt != S_RUN);
        busy_nxt       = (state_nxt != S_IDLE);
        frame_done_nxt = (state_nxt == S_DONE);
    end

    assign dm.dm_width  = width_q;
    assign dm.dm_height = height_q;
    assign dm.dm_crop_w = crop_w_q;
    assign dm.dm_crop_h = crop_h_q;
    assign dm.dm_reset  = dm_reset_q;
    assign dm.wr_en     = wr_en_q;
    assign dm.wr_adr    = wr_adr_q;

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign pix_count  = pix_q;

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// Directed self-checking bench for isp_frame_sequencer (watchdog width 4).
module tb_isp_frame_sequencer;

    localparam logic [31:0] BASE = 32'h0020_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic [15:0] cfg_crop_w;
    logic [15:0] cfg_crop_h;
    logic        busy;
    logic        frame_done;
    logic [2:0]  err;
    logic [31:0] pix_count;

    int checks;
    int errors;
    int n;

    isp_frame_sequencer_if dm_if ();

    isp_frame_sequencer #(
        .OUT_BASE  (BASE),
        .TIMEOUT_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_crop_w (cfg_crop_w),
        .cfg_crop_h (cfg_crop_h),
        .dm         (dm_if),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .pix_count  (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are stable 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] w, input logic [15:0] h,
                           input logic [15:0] cw, input logic [15:0] ch);
        cfg_width  = w;
        cfg_height = h;
        cfg_crop_w = cw;
        cfg_crop_h = ch;
    endtask

    // Accepted start followed by the two clear cycles; ends in RUN
    task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
        set_cfg(w, h, w, h);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic feed(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            dm_if.dm_data_v = 1'b1;
            tick();
        end
        dm_if.dm_data_v = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},     32'(busy),            32'd0);
        check({tag, "_dmrst"},    32'(dm_if.dm_reset),  32'd1);
        check({tag, "_fdone"},    32'(frame_done),      32'd0);
        check({tag, "_wren"},     32'(dm_if.wr_en),     32'd0);
        check({tag, "_wradr"},    dm_if.wr_adr,         32'd0);
        check({tag, "_err"},      32'(err),             32'd0);
        check({tag, "_pix"},      pix_count,            32'd0);
        check({tag, "_width"},    32'(dm_if.dm_width),  32'd0);
        check({tag, "_height"},   32'(dm_if.dm_height), 32'd0);
        check({tag, "_crop_w"},   32'(dm_if.dm_crop_w), 32'd0);
        check({tag, "_crop_h"},   32'(dm_if.dm_crop_h), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        start = 1'b0;
        set_cfg(16'd0, 16'd0, 16'd0, 16'd0);
        dm_if.dm_data_v = 1'b0;
        dm_if.dm_done   = 1'b0;
        tick();
        tick();
        check_reset_vals("por");
        reset = 1'b1;
        tick();

        // Nominal 4x4 frame
        set_cfg(16'd4, 16'd4, 16'd3, 16'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clr1_busy",  32'(busy),            32'd1);
        check("clr1_dmrst", 32'(dm_if.dm_reset),  32'd1);
        check("clr1_width", 32'(dm_if.dm_width),  32'd4);
        check("clr1_croph", 32'(dm_if.dm_crop_h), 32'd2);
        tick();
        check("clr2_dmrst", 32'(dm_if.dm_reset), 32'd1);
        tick();
        check("run_dmrst",  32'(dm_if.dm_reset), 32'd0);
        check("run_wren0",  32'(dm_if.wr_en),    32'd0);
        for (int i = 0; i < 16; i++) begin
            dm_if.dm_data_v = 1'b1;
            tick();
            check("f1_wren",  32'(dm_if.wr_en), 32'd1);
            check("f1_wradr", dm_if.wr_adr,     BASE + 32'(i));
        end
        dm_if.dm_data_v = 1'b0;
        dm_if.dm_done   = 1'b1;
        tick();
        dm_if.dm_done   = 1'b0;
        check("f1_fdone", 32'(frame_done),   32'd1);
        check("f1_wren_off", 32'(dm_if.wr_en), 32'd0);
        check("f1_err",   32'(err),          32'd0);
        check("f1_pix",   pix_count,         32'd16);
        check("f1_done_dmrst", 32'(dm_if.dm_reset), 32'd1);
        tick();
        check("f1_idle_fdone", 32'(frame_done), 32'd0);
        check("f1_idle_busy",  32'(busy),       32'd0);

        // Short frame: count mismatch
        start_frame(16'd4, 16'd4);
        feed(15);
        dm_if.dm_done = 1'b1;
        tick();
        dm_if.dm_done = 1'b0;
        check("f2_fdone", 32'(frame_done), 32'd1);
        check("f2_err",   32'(err),        32'd1);
        check("f2_pix",   pix_count,       32'd15);
        tick();

        // Watchdog expiry after 3 pixels
        start_frame(16'd4, 16'd4);
        feed(3);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (frame_done) begin
                n = i;
                break;
            end
        end
        check("wd_latency", 32'(n),        32'd15);
        check("wd_err",     32'(err),      32'd2);
        check("wd_pix",     pix_count,     32'd3);
        tick();
        check("wd_idle",    32'(busy),     32'd0);

        // dm_done on the expiry cycle of a complete frame
        start_frame(16'd4, 16'd4);
        feed(16);
        for (int i = 1; i <= 14; i++) tick();
        check("wd2_nodone", 32'(frame_done), 32'd0);
        dm_if.dm_done = 1'b1;
        tick();
        dm_if.dm_done = 1'b0;
        check("wd2_fdone", 32'(frame_done), 32'd1);
        check("wd2_err",   32'(err),        32'd0);
        tick();

        // Bad geometry request
        set_cfg(16'd1, 16'd4, 16'd9, 16'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bad_err",    32'(err),            32'd4);
        check("bad_busy",   32'(busy),           32'd0);
        check("bad_dmrst",  32'(dm_if.dm_reset), 32'd1);
        check("bad_width",  32'(dm_if.dm_width), 32'd4);
        check("bad_cropw",  32'(dm_if.dm_crop_w), 32'd4);
        check("bad_fdone",  32'(frame_done),     32'd0);
        tick();
        check("bad_sticky", 32'(err),            32'd4);

        // Valid start clears err; then mid-frame start and cfg changes
        set_cfg(16'd6, 16'd2, 16'd3, 16'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ok_err",   32'(err),             32'd0);
        check("ok_width", 32'(dm_if.dm_width),  32'd6);
        check("ok_croph", 32'(dm_if.dm_crop_h), 32'd1);
        tick();
        tick();
        feed(2);
        set_cfg(16'd8, 16'd8, 16'd8, 16'd8);
        start = 1'b1;
        dm_if.dm_data_v = 1'b1;
        tick();
        start = 1'b0;
        check("mid_width", 32'(dm_if.dm_width), 32'd6);
        check("mid_cropw", 32'(dm_if.dm_crop_w), 32'd3);
        check("mid_dmrst", 32'(dm_if.dm_reset), 32'd0);
        check("mid_pix",   pix_count,           32'd3);
        feed(9);
        dm_if.dm_done = 1'b1;
        tick();
        dm_if.dm_done = 1'b0;
        check("mid_fdone", 32'(frame_done), 32'd1);
        check("mid_err",   32'(err),        32'd0);
        check("mid_pix12", pix_count,       32'd12);
        tick();
        tick();
        check("noqueue_busy", 32'(busy), 32'd0);

        // Strobes outside RUN are ignored
        dm_if.dm_data_v = 1'b1;
        dm_if.dm_done   = 1'b1;
        tick();
        tick();
        dm_if.dm_data_v = 1'b0;
        dm_if.dm_done   = 1'b0;
        check("idle_wren",  32'(dm_if.wr_en), 32'd0);
        check("idle_pix",   pix_count,        32'd12);
        check("idle_fdone", 32'(frame_done),  32'd0);
        check("idle_busy",  32'(busy),        32'd0);

        // Reset in the middle of a frame
        start_frame(16'd4, 16'd4);
        feed(5);
        check("prerst_pix", pix_count, 32'd5);
        reset = 1'b0;
        dm_if.dm_data_v = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b1;
        dm_if.dm_data_v = 1'b0;
        tick();
        check("postrst_fdone", 32'(frame_done), 32'd0);
        check("postrst_busy",  32'(busy),       32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
